// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, instruction memory initiator and IF/ID register with start/stall/flush/branch/halt control
module instruction_fetch #(
  parameter int          RESET_PC  = 0,
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  output logic        busy,
  output logic [15:0] fetch_count
);
  localparam int AW = $clog2(MEM_WORDS);
  typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_out_q, pc_out_d;
  logic [31:0]   instr_q, instr_d;
  logic          valid_q, valid_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          unused_target_hi;
  assign unused_target_hi = ^branch_target[31:AW];
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    if (state_q != FETCH) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
      state_d = (start && !(state_q == HALTED && halt)) ? FETCH : state_q;
    end else if (halt) begin
      state_d = HALTED;
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (branch_taken) begin
      pc_d    = branch_target[AW-1:0];
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (!stall) begin
      instr_d  = imem_data;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = (pc_q == AW'(MEM_WORDS - 1)) ? '0 : pc_q + 1'b1;
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= AW'(RESET_PC);
      pc_out_q <= '0;
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end
  assign imem_addr   = {{(32-AW){1'b0}}, pc_q};
  assign instr       = instr_q;
  assign pc_out      = {{(32-AW){1'b0}}, pc_out_q};
  assign instr_valid = valid_q;
  assign busy        = (state_q == FETCH);
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed plan plus randomized control checked against a behavioural fetch model
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n, start, stall, flush, branch_taken, halt;
  logic [31:0] branch_target, imem_addr, imem_data, instr, pc_out;
  logic        instr_valid, busy;
  logic [15:0] fetch_count;
  logic [31:0] mem [128];
  int          tests = 0, fails = 0;
  int          m_state, m_pc, m_instr, m_pcout, m_valid, m_cnt;
  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[6:0]];
  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
    .imem_addr(imem_addr), .imem_data(imem_data), .instr(instr), .pc_out(pc_out),
    .instr_valid(instr_valid), .busy(busy), .fetch_count(fetch_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0; m_cnt = 0;
  endtask
  // states: 0 idle, 1 fetching, 2 halted
  task automatic model_step();
    if (m_state != 1) begin
      m_valid = 0; m_instr = 0;
      if (start && !(m_state == 2 && halt)) m_state = 1;
    end else if (halt) begin
      m_state = 2; m_valid = 0; m_instr = 0;
    end else if (branch_taken) begin
      m_pc = branch_target % 128; m_valid = 0; m_instr = 0;
    end else if (flush) begin
      m_valid = 0; m_instr = 0;
    end else if (!stall) begin
      m_instr = mem[m_pc]; m_pcout = m_pc; m_valid = 1;
      m_pc = (m_pc + 1) % 128;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
  endtask
  task automatic check_all();
    chk("instr", instr, m_instr);
    chk("pc_out", pc_out, m_pcout);
    chk("valid", {31'b0, instr_valid}, m_valid);
    chk("busy", {31'b0, busy}, (m_state == 1) ? 1 : 0);
    chk("count", {16'b0, fetch_count}, m_cnt);
    chk("imem_addr", imem_addr, m_pc);
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle_in();
    start = 0; stall = 0; flush = 0; branch_taken = 0; halt = 0; branch_target = 0;
  endtask
  initial begin
    mem[0] = 32'hA00000AA;
    for (int k = 1; k < 10; k++) mem[k] = (k << 28) | (k * 32'h11);
    for (int k = 10; k < 128; k++) mem[k] = $urandom;
    idle_in();
    rst_n = 0;
    model_reset();
    #12;
    check_all();
    rst_n = 1;
    cyc();
    start = 1; cyc(); start = 0;
    cyc(); chk("p_i0", instr, 32'hA00000AA); chk("p_pc0", pc_out, 0);
    cyc(); chk("p_i1", instr, 32'h10000011);
    cyc(); chk("p_i2", instr, 32'h20000022); chk("p_cnt3", {16'b0, fetch_count}, 3);
    cyc(); chk("p_i3", instr, 32'h30000033);
    stall = 1;
    repeat (3) begin
      cyc(); chk("p_stall_i", instr, 32'h30000033); chk("p_stall_pc", pc_out, 3);
      chk("p_stall_cnt", {16'b0, fetch_count}, 4);
    end
    stall = 0;
    cyc(); chk("p_i4", instr, 32'h40000044);
    halt = 1; cyc(); halt = 0;
    chk("p_halt_v", {31'b0, instr_valid}, 0); chk("p_halt_b", {31'b0, busy}, 0);
    cyc();
    start = 1; halt = 1; cyc(); halt = 0; chk("p_both_b", {31'b0, busy}, 0);
    cyc(); start = 0;
    cyc(); chk("p_res_i", instr, 32'h50000055); chk("p_res_pc", pc_out, 5);
    branch_taken = 1; branch_target = 8; stall = 1; cyc();
    branch_taken = 0; stall = 0;
    chk("p_br_v", {31'b0, instr_valid}, 0); chk("p_br_i", instr, 0);
    cyc(); chk("p_br_i8", instr, 32'h80000088); chk("p_br_pc8", pc_out, 8);
    flush = 1; cyc(); flush = 0; chk("p_fl_v", {31'b0, instr_valid}, 0);
    cyc(); chk("p_fl_i9", instr, 32'h90000099);
    branch_taken = 1; branch_target = 127; cyc(); branch_taken = 0;
    cyc(); chk("p_w127", instr, mem[127]); chk("p_wpc127", pc_out, 127);
    cyc(); chk("p_w0", instr, 32'hA00000AA); chk("p_wpc0", pc_out, 0);
    branch_taken = 1; branch_target = 130; cyc(); branch_taken = 0;
    chk("p_t130", imem_addr, 2);
    cyc(); chk("p_t130_i", instr, 32'h20000022);
    for (int n = 0; n < 400; n++) begin
      start = ($urandom_range(0, 7) == 0);
      halt = ($urandom_range(0, 19) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      branch_target = $urandom;
      cyc();
    end
    idle_in();
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    #3 rst_n = 0;
    #1;
    model_reset();
    chk("r_instr", instr, 0);
    chk("r_valid", {31'b0, instr_valid}, 0);
    chk("r_cnt", {16'b0, fetch_count}, 0);
    chk("r_addr", imem_addr, 0);
    chk("r_busy", {31'b0, busy}, 0);
    #2 rst_n = 1;
    repeat (3) cyc();
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Initiator side of the instruction memory interface: owns the program counter, drives the word address to the instruction memory, and captures the returned word into an IF/ID register.
- Memory is word-addressed with a combinational read: `data = words[address]`, 128 words of 32 bits.
- Sits between the instruction memory and the decode stage.
- Supports start, stall, flush, branch redirect and halt, and counts fetches.

Parameters:
- RESET_PC, 0: PC value after reset; word index.
- MEM_WORDS, 128: instruction memory depth in words; must be a power of 2. PC wraps modulo MEM_WORDS.
- NOP_WORD, 32'h00000000: value loaded into `instr` when the IF/ID register is empty or squashed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  leave IDLE or HALTED and begin or resume fetching
- stall  input  1  hold PC and IF/ID contents
- flush  input  1  squash IF/ID contents; PC held
- branch_taken  input  1  redirect PC to `branch_target`
- branch_target  input  32  word index of the new PC
- halt  input  1  stop fetching
- imem_addr  output  32  word address to the instruction memory; combinationally equal to PC
- imem_data  input  32  instruction word returned by the memory (combinational)
- instr  output  32  registered instruction (IF/ID)
- pc_out  output  32  PC from which `instr` was fetched
- instr_valid  output  1  `instr` holds a live instruction
- busy  output  1  high when state is FETCH
- fetch_count  output  16  number of accepted fetches; saturates at 16'hFFFF

Behaviour:
- Reset (`rst_n` low, asynchronous): PC=RESET_PC, state=IDLE, `instr`=NOP_WORD, `pc_out`=0, `instr_valid`=0, `fetch_count`=0, `busy`=0. `imem_addr` follows PC, so it reads RESET_PC during reset.
- Reset asserted mid-operation: all of the above take effect immediately. No partial fetch survives.
- States:
  - IDLE: no fetch. `start`=1 -> FETCH.
  - FETCH: fetching each cycle. `halt`=1 -> HALTED.
  - HALTED: no fetch. `start`=1 -> FETCH; PC is resumed, not reset. `halt` and `start` both high -> stays HALTED.
- IDLE and HALTED: PC and `fetch_count` hold. `instr_valid` reads 0 one edge after entry.
- FETCH, per rising edge, priority highest first:
  1. `halt`: go to HALTED; `instr_valid`<=0, `instr`<=NOP_WORD; PC held.
  2. `branch_taken`: PC <= `branch_target[log2(MEM_WORDS)-1:0]`, zero-extended; `instr_valid`<=0, `instr`<=NOP_WORD. Overrides `stall` and `flush`. Counter unchanged.
  3. `flush`: `instr_valid`<=0, `instr`<=NOP_WORD; PC held, so the same word is refetched next cycle.
  4. `stall`: PC, `instr`, `pc_out`, `instr_valid` and `fetch_count` all hold.
  5. Normal fetch:
     - `instr`<=`imem_data`, `pc_out`<=PC, `instr_valid`<=1
     - PC <= (PC==MEM_WORDS-1) ? 0 : PC+1
     - `fetch_count`<=`fetch_count`+1, saturating
- Latency: `start` sampled at edge k -> FETCH after edge k. At edge k+1, `instr`=mem[PC] and `instr_valid`=1. Steady state is one instruction per cycle.
- Branch penalty: one bubble. The edge that applies the branch clears `instr_valid`; the next edge delivers mem[target].
- Wrap-around: PC never exceeds MEM_WORDS-1. The upper bits of `imem_addr` are always 0.
- `start` while in FETCH is ignored.

Test Plan:
- Memory preloaded mem[0..9] = A00000AA, 10000011, 20000022, …, 90000099 (mem[k] = k0000kk for k=1..9). Reset, pulse `start` -> on successive edges `instr` = A00000AA, 10000011, 20000022; `pc_out` = 0, 1, 2; `instr_valid`=1; `fetch_count`=3.
- `stall` high for 3 cycles while `instr`=30000033 -> `instr`, `pc_out`=3 and `fetch_count` are frozen; after release the next `instr` is 40000044.
- `branch_taken`=1 with `branch_target`=8 while `stall`=1 -> next edge `instr_valid`=0 and `instr`=0; following edge `instr`=80000088, `pc_out`=8.
- PC at 127 -> fetch mem[127], then PC=0 and next `instr`=A00000AA. `branch_target`=130 -> PC=2.
- `halt` during fetch at PC=5 -> HALTED, `instr_valid`=0, `busy`=0. Later `start` -> `instr`=50000055, `pc_out`=5.
- `rst_n` low mid-stream -> immediately, without waiting for a clock edge: `instr`=0, `instr_valid`=0, `fetch_count`=0, `imem_addr`=0; state is IDLE until `start`.
